multicycle_main_fsm: RTL and testbench
======================================

# multicycle_main_fsm

Main control state machine for the multicycle ARM processor. It sequences the shared datapath (instruction/data memory port, register file, single ALU, PC register) through fetch, decode, execute, memory and writeback steps. It drives the ALU decoder's `ALUOp`, and a downstream conditional-logic block combines its `RegW`/`MemW`/`Branch` with flag checks and `NoWrite`. Memory accesses stall on a ready handshake.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: synchronous reset, active low.
- `Op` in 2: instruction class, Instr[27:26]. 00 = data-processing, 01 = memory, 10 = branch, 11 = undefined.
- `Funct` in 6: Instr[25:20]. Bit 5 = I (immediate), bit 0 = S or L (load).
- `MemReady` in 1: memory completes the current access this cycle.
- `IRWrite` out 1: instruction register load enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALU result register.
- `ALUSrcA` out 2: ALU A select. 00 = RD1 register, 01 = PC.
- `ALUSrcB` out 2: ALU B select. 00 = RD2 register, 01 = ExtImm, 10 = constant 4.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data register, 10 = ALU result (direct).
- `ALUOp` out 2: to the ALU decoder. 00 = add, 10 = decode from Funct.
- `NextPC` out 1: PC write enable, unconditional.
- `RegW` out 1: register write request, before condition gating.
- `MemW` out 1: memory write request, before condition gating.
- `Branch` out 1: branch request, before condition gating.
- `InstrDone` out 1: one-cycle pulse when an instruction retires.
- `Illegal` out 1: sticky undefined-instruction indicator.

## Operation
- State register with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH and TRAP.
- Any output not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = NextPC = MemReady.
  - Stays in FETCH while !MemReady; goes to DECODE when MemReady.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10 (forms PC+8). Next state by `Op`:
  - 01 → MEMADR.
  - 00 with Funct[5]=0 → EXECR.
  - 00 with Funct[5]=1 → EXECI.
  - 10 → BRANCH.
  - 11 → TRAP or FETCH (see Configuration).
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALUOp=00. Goes to MEMREAD if Funct[0]=1, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1, InstrDone=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemW=1.
  - MemW stays asserted every cycle until MemReady.
  - InstrDone = MemReady.
  - Goes to FETCH on MemReady.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegW=1, InstrDone=1. Goes to FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ALUOp=00, ResultSrc=10, Branch=1, InstrDone=1. Goes to FETCH.
- TRAP: Illegal=1. All enables are 0. Only reset leaves TRAP.
- `Op` and `Funct` are sampled only in DECODE and MEMADR. They come from the IR, which is stable after FETCH.

## Timing
- Outputs are combinational from the state register, plus `MemReady` gating in FETCH and MEMWRITE.
- State updates on the rising edge of `clk`.
- When `reset_n`=0 at a clock edge, the next state is FETCH and `Illegal` clears.
- While `reset_n`=0, IRWrite, NextPC, RegW, MemW, Branch and InstrDone are forced to 0. The mux selects show their FETCH values.
- Reset during any state, including a stalled MEMWRITE, aborts that state with no further enables.
- Minimum cycles with MemReady always 1:
  - Load: 5.
  - Store: 4.
  - Data-processing: 4.
  - Branch: 3.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- NextPC and IRWrite pulse high exactly once per instruction, in the same cycle.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - DECODE with Op=11 goes to TRAP.
  - `Illegal` rises the next cycle and stays high until reset.
- `ILLEGAL_TRAP_EN` undefined:
  - TRAP is not compiled in.
  - DECODE with Op=11 goes to FETCH with InstrDone=1, so the instruction acts as a NOP.
  - `Illegal` is tied to 0.

## Structure
- Shared package `arm_ctrl_pkg` holds:
  - The state enumeration.
  - Localparams for the AdrSrc, ALUSrcA, ALUSrcB and ResultSrc encodings.
  - The ALUOp encodings, also used by the ALU decoder.
  - The Op class constants.
- One sub-module, `main_fsm_outputs`: a combinational state-to-control-word decode. The top level holds the state register, next-state logic and MemReady gating.

## Test plan
- Reset with `reset_n`=0 for 2 cycles, MemReady=1 → state FETCH, all enables 0 during reset. IRWrite=NextPC=1 in the first cycle after release.
- Data-processing register form (Op=00, Funct=000100), MemReady=1 → FETCH, DECODE, EXECR (ALUOp=10), ALUWB (RegW=1, InstrDone=1), back to FETCH at cycle 4.
- Load (Op=01, Funct=011001) with MemReady=0 for 3 cycles in MEMREAD → MEMREAD held 4 cycles, then MEMWB with ResultSrc=01 and RegW=1. Total 8 cycles.
- Store (Op=01, Funct=011000) with MemReady low 2 cycles → MemW=1 for 3 consecutive cycles. InstrDone only in the MemReady cycle.
- Branch (Op=10) → BRANCH state with Branch=1, ALUSrcB=01, ResultSrc=10. Next fetch at cycle 3.
- Op=11 → with `ILLEGAL_TRAP_EN`, Illegal=1 and held for 10 cycles until reset clears it. Without the macro, a FETCH follows DECODE and Illegal stays 0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared encodings for the multicycle ARM control path
package arm_ctrl_pkg;

  // FSM state codes
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_TRAP     = 4'd10;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCA_RD1   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       instr_done;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/main_fsm_outputs.sv
// rtl/main_fsm_outputs.sv - combinational state-to-control-word decode
// mem_ready gates the handshake-dependent enables in FETCH and MEMWRITE.
module main_fsm_outputs
  import arm_ctrl_pkg::*;
(
  input  logic [3:0]  state,
  input  logic        mem_ready,
  output ctrl_word_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.adr_src    = ADR_PC;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.ir_write   = mem_ready;
        ctrl.next_pc    = mem_ready;
      end
      S_DECODE: begin
        // PC already advanced by 4, so this forms PC+8 for R15 reads
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.adr_src    = ADR_ALUOUT;
        ctrl.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_w      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.adr_src    = ADR_ALUOUT;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_w      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXECR: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_RD2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ctrl.alu_src_a = SRCA_RD1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_w      = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RD1;
        ctrl.alu_src_b  = SRCB_IMM;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALU;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP: begin
        ctrl.illegal = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_main_fsm.sv
// rtl/multicycle_main_fsm.sv - multicycle ARM main control FSM
// Define ILLEGAL_TRAP_EN to make Op=11 lock into a sticky TRAP state instead of a NOP.
module multicycle_main_fsm
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       InstrDone,
  output logic       Illegal
);

  logic [3:0] state;
  logic [3:0] next_state;
  logic [3:0] dec_state;
  logic       dec_ready;
  logic       nop_done;
  logic       unused_funct;
  ctrl_word_t ctrl;

  assign unused_funct = ^Funct[4:1];

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (MemReady) next_state = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  next_state = S_MEMADR;
          OP_DP:   next_state = Funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   next_state = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default: next_state = S_TRAP;
`else
          default: next_state = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (MemReady) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (MemReady) next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     next_state = S_TRAP;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // Reset shows FETCH selects with the ready handshake masked, so no enable can fire
  assign dec_state = reset_n ? state : S_FETCH;
  assign dec_ready = MemReady & reset_n;

  main_fsm_outputs u_outputs (
    .state     (dec_state),
    .mem_ready (dec_ready),
    .ctrl      (ctrl)
  );

`ifdef ILLEGAL_TRAP_EN
  assign nop_done = 1'b0;
`else
  assign nop_done = reset_n && (state == S_DECODE) && (Op == OP_UNDEF);
`endif

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign ALUOp     = ctrl.alu_op;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign InstrDone = ctrl.instr_done | nop_done;
  assign Illegal   = ctrl.illegal;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// tb/tb_multicycle_main_fsm.sv - directed bench for multicycle_main_fsm
// Control word order: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,NextPC,RegW,MemW,Branch,InstrDone,Illegal}
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       MemReady;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, InstrDone, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_main_fsm dut (
    .clk(clk), .reset_n(reset_n), .Op(Op), .Funct(Funct), .MemReady(MemReady),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .Branch(Branch), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  localparam logic [15:0] W_FETCH   = {1'b1,1'b0,2'b01,2'b10,2'b10,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_FSTALL  = {1'b0,1'b0,2'b01,2'b10,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_DECODE  = W_FSTALL;
  localparam logic [15:0] W_NOP     = {1'b0,1'b0,2'b01,2'b10,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] W_MEMADR  = {1'b0,1'b0,2'b00,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_MEMREAD = {1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_MEMWB   = {1'b0,1'b0,2'b00,2'b00,2'b01,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] W_MWSTALL = {1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_MWDONE  = {1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
  localparam logic [15:0] W_EXECR   = {1'b0,1'b0,2'b00,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_EXECI   = {1'b0,1'b0,2'b00,2'b01,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam logic [15:0] W_ALUWB   = {1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b1,1'b0};
  localparam logic [15:0] W_BRANCH  = {1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0};
  localparam logic [15:0] W_TRAP    = {1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
  localparam logic [15:0] W_RESET   = W_FSTALL;

  function automatic logic [15:0] obs_word();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp,
            NextPC, RegW, MemW, Branch, InstrDone, Illegal};
  endfunction

  // Let inputs settle, compare the combinational word, then advance one clock
  task automatic cyc(input string tag, input logic [15:0] exp);
    logic [15:0] obs;
    #1;
    obs = obs_word();
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; MemReady = 1'b1; Op = 2'b00; Funct = 6'b000000;
    @(posedge clk); #1;
    cyc("reset_c0", W_RESET);
    cyc("reset_c1", W_RESET);
    reset_n = 1'b1;

    // Data-processing register form
    Op = 2'b00; Funct = 6'b000100;
    cyc("dpr_fetch", W_FETCH);
    cyc("dpr_decode", W_DECODE);
    cyc("dpr_execr", W_EXECR);
    cyc("dpr_aluwb", W_ALUWB);

    // Data-processing immediate form, with one fetch stall
    Op = 2'b00; Funct = 6'b100100;
    MemReady = 1'b0;
    cyc("dpi_fetch_stall", W_FSTALL);
    MemReady = 1'b1;
    cyc("dpi_fetch", W_FETCH);
    cyc("dpi_decode", W_DECODE);
    cyc("dpi_execi", W_EXECI);
    cyc("dpi_aluwb", W_ALUWB);

    // Load with three wait cycles in MEMREAD
    Op = 2'b01; Funct = 6'b011001;
    cyc("ld_fetch", W_FETCH);
    cyc("ld_decode", W_DECODE);
    cyc("ld_memadr", W_MEMADR);
    MemReady = 1'b0;
    cyc("ld_memread_w0", W_MEMREAD);
    cyc("ld_memread_w1", W_MEMREAD);
    cyc("ld_memread_w2", W_MEMREAD);
    MemReady = 1'b1;
    cyc("ld_memread_rdy", W_MEMREAD);
    cyc("ld_memwb", W_MEMWB);

    // Store with two wait cycles
    Op = 2'b01; Funct = 6'b011000;
    cyc("st_fetch", W_FETCH);
    cyc("st_decode", W_DECODE);
    cyc("st_memadr", W_MEMADR);
    MemReady = 1'b0;
    cyc("st_memw_w0", W_MWSTALL);
    cyc("st_memw_w1", W_MWSTALL);
    MemReady = 1'b1;
    cyc("st_memw_done", W_MWDONE);

    // Branch
    Op = 2'b10; Funct = 6'b000000;
    cyc("br_fetch", W_FETCH);
    cyc("br_decode", W_DECODE);
    cyc("br_branch", W_BRANCH);

    // Reset while a store is stalled in MEMWRITE
    Op = 2'b01; Funct = 6'b011000;
    cyc("rst_st_fetch", W_FETCH);
    cyc("rst_st_decode", W_DECODE);
    cyc("rst_st_memadr", W_MEMADR);
    MemReady = 1'b0;
    cyc("rst_st_memw", W_MWSTALL);
    reset_n = 1'b0;
    cyc("rst_st_abort", W_RESET);
    reset_n = 1'b1; MemReady = 1'b1;
    Op = 2'b10;
    cyc("rst_st_refetch", W_FETCH);
    cyc("rst_br_decode", W_DECODE);
    cyc("rst_br_branch", W_BRANCH);

    // Undefined instruction class
    Op = 2'b11; Funct = 6'b000000;
    cyc("ud_fetch", W_FETCH);
`ifdef ILLEGAL_TRAP_EN
    cyc("ud_decode", W_DECODE);
    for (int i = 0; i < 10; i++) cyc("ud_trap_hold", W_TRAP);
    reset_n = 1'b0;
    cyc("ud_trap_reset", W_RESET);
    reset_n = 1'b1;
    Op = 2'b00; Funct = 6'b000100;
    cyc("ud_after_fetch", W_FETCH);
`else
    cyc("ud_decode_nop", W_NOP);
    Op = 2'b00; Funct = 6'b000100;
    cyc("ud_next_fetch", W_FETCH);
`endif
    cyc("ud_after_decode", W_DECODE);
    cyc("ud_after_execr", W_EXECR);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
